// File: rtl/jtframe_dump_ctrl.sv
// Multi-channel dump window controller.
// Counts frames on vertical-sync falling edges and opens a per-channel
// dump_en window on reset release, on a chosen frame or at the end of ROM
// download. The window stays open for a programmable number of frames.
module jtframe_dump_ctrl #(
  parameter int CH    = 4,
  parameter int FW    = 32,
  parameter int LENW  = 16,
  parameter int GUARD = 2000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 vs_i,
  input  logic                 led_i,
  input  logic [2*CH-1:0]      mode_i,
  input  logic [FW*CH-1:0]     start_frame_i,
  input  logic [LENW*CH-1:0]   len_i,
  input  logic [CH-1:0]        rearm_i,
  output logic [FW-1:0]        frame_cnt_o,
  output logic [CH-1:0]        dump_en_o,
  output logic [CH-1:0]        dump_start_o,
  output logic [CH-1:0]        dump_stop_o,
  output logic                 busy_o
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACTIVE,
    S_DONE
  } state_t;

  logic          vs_l_q;
  logic          led_l_q;
  logic [FW-1:0] frame_cnt_q;
  logic [GW-1:0] guard_q;
  logic          started_q;
  logic          busy_q;
  logic [CH-1:0] en_d;

  logic vs_fall;
  logic led_fall;
  logic guard_ok;

  assign vs_fall  = vs_l_q & ~vs_i;
  assign led_fall = led_l_q & ~led_i;
  assign guard_ok = (guard_q == GW'(GUARD));

  // Shared state: edge-detect copies, frame counter, download guard timer,
  // the settle flag that holds channels in IDLE for the first edge after
  // reset release, and the registered busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_l_q      <= 1'b0;
      led_l_q     <= 1'b0;
      frame_cnt_q <= '0;
      guard_q     <= '0;
      started_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      vs_l_q    <= vs_i;
      led_l_q   <= led_i;
      started_q <= 1'b1;
      busy_q    <= |en_d;
      if (vs_fall) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (!guard_ok) begin
        guard_q <= guard_q + 1'b1;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = busy_q;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [1:0]      mode_w;
      logic [FW-1:0]   start_w;
      logic [LENW-1:0] len_w;
      state_t          state_q;
      logic [LENW-1:0] remaining_q;
      logic            en_q;
      logic            start_q;
      logic            stop_q;
      logic            fire_w;
      logic            finish_w;

      assign mode_w  = mode_i[2*gi +: 2];
      assign start_w = start_frame_i[FW*gi +: FW];
      assign len_w   = len_i[LENW*gi +: LENW];

      // Trigger condition for the selected mode; mode 0 never fires so a
      // simultaneous trigger and mode 0 falls back to IDLE.
      always_comb begin
        fire_w = 1'b0;
        case (mode_w)
          2'd1:    fire_w = 1'b1;
          2'd2:    fire_w = vs_fall && (frame_cnt_q == start_w);
          2'd3:    fire_w = led_fall && guard_ok;
          default: fire_w = 1'b0;
        endcase
      end

      assign finish_w = vs_fall && (len_w != '0) && (remaining_q == LENW'(1));
      assign en_d[gi] = ((state_q == S_ARMED) && fire_w) ||
                        ((state_q == S_ACTIVE) && !finish_w);

      // Channel FSM with registered window flag and edge pulses.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q     <= S_IDLE;
          remaining_q <= '0;
          en_q        <= 1'b0;
          start_q     <= 1'b0;
          stop_q      <= 1'b0;
        end else begin
          en_q    <= en_d[gi];
          start_q <= en_d[gi] & ~en_q;
          stop_q  <= ~en_d[gi] & en_q;
          case (state_q)
            S_IDLE: begin
              if (started_q && (mode_w != 2'd0)) begin
                state_q <= S_ARMED;
              end
            end
            S_ARMED: begin
              if (mode_w == 2'd0) begin
                state_q <= S_IDLE;
              end else if (fire_w) begin
                state_q     <= S_ACTIVE;
                remaining_q <= len_w;
              end
            end
            S_ACTIVE: begin
              // len of zero keeps the window open indefinitely
              if (vs_fall && (len_w != '0)) begin
                if (remaining_q == LENW'(1)) begin
                  state_q <= S_DONE;
                end else begin
                  remaining_q <= remaining_q - 1'b1;
                end
              end
            end
            S_DONE: begin
              if (rearm_i[gi]) begin
                state_q <= S_ARMED;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end

      assign dump_en_o[gi]    = en_q;
      assign dump_start_o[gi] = start_q;
      assign dump_stop_o[gi]  = stop_q;
    end
  endgenerate

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Directed bench for jtframe_dump_ctrl: one task per scenario, inline checks.
module tb_jtframe_dump_ctrl;
  localparam int CH    = 4;
  localparam int FW    = 4;
  localparam int LENW  = 16;
  localparam int GUARD = 100;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 vs = 1'b0;
  logic                 led = 1'b0;
  logic [2*CH-1:0]      mode = '0;
  logic [FW*CH-1:0]     start_frame = '0;
  logic [LENW*CH-1:0]   len = '0;
  logic [CH-1:0]        rearm = '0;
  logic [FW-1:0]        frame_cnt;
  logic [CH-1:0]        dump_en;
  logic [CH-1:0]        dump_start;
  logic [CH-1:0]        dump_stop;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int start_cnt [CH];
  int stop_cnt  [CH];

  jtframe_dump_ctrl #(.CH(CH), .FW(FW), .LENW(LENW), .GUARD(GUARD)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .vs_i          (vs),
    .led_i         (led),
    .mode_i        (mode),
    .start_frame_i (start_frame),
    .len_i         (len),
    .rearm_i       (rearm),
    .frame_cnt_o   (frame_cnt),
    .dump_en_o     (dump_en),
    .dump_start_o  (dump_start),
    .dump_stop_o   (dump_stop),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  // pulse tally, sampled away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < CH; i++) begin
      if (dump_start[i]) start_cnt[i]++;
      if (dump_stop[i])  stop_cnt[i]++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // one vs falling edge happens on the second edge
  task automatic frame;
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({frame_cnt, dump_en, dump_start, dump_stop, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d en=%b st=%b sp=%b busy=%b required all 0",
               frame_cnt, dump_en, dump_start, dump_stop, busy);
    end
    $display("test_reset: cnt=%0d en=%b busy=%b", frame_cnt, dump_en, busy);
  endtask

  task automatic test_mode1;
    int s0, p0;
    mode = 8'b0000_0001;
    len = '0;
    do_reset();
    s0 = start_cnt[0];
    p0 = stop_cnt[0];
    tick();
    tick();
    checks++;
    if (dump_en[0] !== 1'b0) begin
      errors++;
      $display("FAIL m1_edge2: dump_en[0]=%b required 0", dump_en[0]);
    end
    tick();
    checks++;
    if ({dump_en[0], dump_start[0], busy} !== 3'b111) begin
      errors++;
      $display("FAIL m1_edge3: en/start/busy=%b required 111", {dump_en[0], dump_start[0], busy});
    end
    tick();
    checks++;
    if (dump_start[0] !== 1'b0) begin
      errors++;
      $display("FAIL m1_start_len: dump_start[0]=%b required 0", dump_start[0]);
    end
    for (int k = 1; k <= 10; k++) begin
      frame();
      checks++;
      if (dump_en[0] !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL m1_hold f%0d: en=%b busy=%b required 1 1", k, dump_en[0], busy);
      end
    end
    checks++;
    if (start_cnt[0] - s0 != 1 || stop_cnt[0] - p0 != 0) begin
      errors++;
      $display("FAIL m1_pulses: starts=%0d stops=%0d required 1 0",
               start_cnt[0] - s0, stop_cnt[0] - p0);
    end
    $display("test_mode1: en=%b cnt=%0d", dump_en, frame_cnt);
  endtask

  task automatic test_frame_trigger;
    int s1, p1;
    logic exp;
    mode = 8'b0000_1000;
    start_frame = '0;
    start_frame[7:4] = 4'd5;
    len = '0;
    len[31:16] = 16'd3;
    do_reset();
    s1 = start_cnt[1];
    p1 = stop_cnt[1];
    for (int k = 1; k <= 9; k++) begin
      frame();
      exp = (k >= 6 && k <= 8);
      checks++;
      if (frame_cnt !== FW'(k) || dump_en[1] !== exp) begin
        errors++;
        $display("FAIL m2_win f%0d: cnt=%0d en=%b required %0d %b", k, frame_cnt, dump_en[1], k, exp);
      end
      if (k == 6) begin
        checks++;
        if (dump_start[1] !== 1'b1) begin
          errors++;
          $display("FAIL m2_start: dump_start[1]=%b required 1", dump_start[1]);
        end
      end
      if (k == 9) begin
        checks++;
        if (dump_stop[1] !== 1'b1) begin
          errors++;
          $display("FAIL m2_stop: dump_stop[1]=%b required 1", dump_stop[1]);
        end
      end
    end
    tick();
    checks++;
    if (start_cnt[1] - s1 != 1 || stop_cnt[1] - p1 != 1) begin
      errors++;
      $display("FAIL m2_pulses: starts=%0d stops=%0d required 1 1",
               start_cnt[1] - s1, stop_cnt[1] - p1);
    end
    $display("test_frame_trigger: cnt=%0d en=%b", frame_cnt, dump_en);
  endtask

  task automatic test_rearm;
    logic exp;
    int   kk;
    start_frame[7:4] = 4'd12;
    rearm[1] = 1'b1;
    tick();
    rearm[1] = 1'b0;
    checks++;
    if (dump_en[1] !== 1'b0) begin
      errors++;
      $display("FAIL rearm_armed: dump_en[1]=%b required 0", dump_en[1]);
    end
    for (int k = 10; k <= 17; k++) begin
      frame();
      kk = k % 16;
      if (kk == 13) begin
        rearm[1] = 1'b1;
        tick();
        rearm[1] = 1'b0;
      end
      exp = (kk >= 13 && kk <= 15);
      checks++;
      if (frame_cnt !== FW'(kk) || dump_en[1] !== exp) begin
        errors++;
        $display("FAIL rearm_win f%0d: cnt=%0d en=%b required %0d %b", k, frame_cnt, dump_en[1], kk, exp);
      end
    end
    $display("test_rearm: cnt=%0d en=%b", frame_cnt, dump_en);
  endtask

  task automatic test_download;
    mode = 8'b0011_0000;
    len = '0;
    len[47:32] = 16'd1;
    led = 1'b1;
    do_reset();
    repeat (49) tick();
    led = 1'b0;
    tick();
    checks++;
    if (dump_en[2] !== 1'b0) begin
      errors++;
      $display("FAIL dl_guard: dump_en[2]=%b required 0", dump_en[2]);
    end
    led = 1'b1;
    repeat (249) tick();
    led = 1'b0;
    tick();
    checks++;
    if ({dump_en[2], dump_start[2], busy} !== 3'b111) begin
      errors++;
      $display("FAIL dl_fire: en/start/busy=%b required 111", {dump_en[2], dump_start[2], busy});
    end
    led = 1'b1;
    frame();
    checks++;
    if ({dump_en[2], dump_stop[2], busy} !== 3'b010) begin
      errors++;
      $display("FAIL dl_done: en/stop/busy=%b required 010", {dump_en[2], dump_stop[2], busy});
    end
    $display("test_download: en=%b busy=%b", dump_en, busy);
  endtask

  task automatic test_wrap;
    logic exp;
    mode = 8'b1000_0000;
    start_frame = '0;
    start_frame[15:12] = 4'd2;
    len = '0;
    len[63:48] = 16'd1;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      frame();
      exp = (k == 3);
      checks++;
      if (frame_cnt !== FW'(k % 16) || dump_en[3] !== exp) begin
        errors++;
        $display("FAIL wrap f%0d: cnt=%0d en=%b required %0d %b", k, frame_cnt, dump_en[3], k % 16, exp);
      end
    end
    $display("test_wrap: cnt=%0d en=%b", frame_cnt, dump_en);
  endtask

  task automatic test_async_reset;
    int p0, p1;
    mode = 8'b0000_1001;
    start_frame = '0;
    start_frame[7:4] = 4'd1;
    len = '0;
    do_reset();
    repeat (3) tick();
    frame();
    frame();
    checks++;
    if (dump_en !== 4'b0011) begin
      errors++;
      $display("FAIL ar_pre: dump_en=%b required 0011", dump_en);
    end
    p0 = stop_cnt[0];
    p1 = stop_cnt[1];
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({frame_cnt, dump_en, dump_start, dump_stop, busy} !== '0) begin
      errors++;
      $display("FAIL ar_async: cnt=%0d en=%b st=%b sp=%b busy=%b required all 0",
               frame_cnt, dump_en, dump_start, dump_stop, busy);
    end
    tick();
    tick();
    checks++;
    if (stop_cnt[0] != p0 || stop_cnt[1] != p1) begin
      errors++;
      $display("FAIL ar_nostop: stops=%0d,%0d required 0,0", stop_cnt[0] - p0, stop_cnt[1] - p1);
    end
    rst_n = 1'b1;
    frame();
    checks++;
    if (frame_cnt !== FW'(1) || dump_en[1] !== 1'b0) begin
      errors++;
      $display("FAIL ar_restart: cnt=%0d en1=%b required 1 0", frame_cnt, dump_en[1]);
    end
    frame();
    checks++;
    if (frame_cnt !== FW'(2) || dump_en[1] !== 1'b1) begin
      errors++;
      $display("FAIL ar_rearm: cnt=%0d en1=%b required 2 1", frame_cnt, dump_en[1]);
    end
    $display("test_async_reset: cnt=%0d en=%b", frame_cnt, dump_en);
  endtask

  initial begin
    test_reset();
    test_mode1();
    test_frame_trigger();
    test_rearm();
    test_download();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jtframe_dump_ctrl.md
Name: jtframe_dump_ctrl

Overview:
- Multi-channel, synthesizable waveform-dump window controller for the simulation harness.
- Counts frames from the vertical-sync falling edge.
- Each channel can arm on one of three triggers: reset release, a chosen frame, or the end of ROM download (led falling edge after a guard time).
- Holds a per-channel dump_en for a programmable number of frames; simulation wrappers gate $dumpon/$dumpoff or $shm_probe scopes from dump_en.

Parameters:
- CH, 4, number of independent dump channels.
- FW, 32, frame counter width.
- LENW, 16, per-channel window length width, in frames.
- GUARD, 2000, clock cycles after reset during which led falling edges are ignored.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vs  in  1  vertical sync, clk-synchronous; a falling edge marks a new frame.
- led  in  1  downloading indicator, clk-synchronous.
- mode  in  2*CH  per channel: 0 off, 1 immediate, 2 frame trigger, 3 download trigger; channel i uses bits [2i+1:2i].
- start_frame  in  FW*CH  per-channel frame number for mode 2.
- len  in  LENW*CH  per-channel window length in frames; 0 means unlimited.
- rearm  in  CH  per-channel pulse; returns a DONE channel to ARMED.
- frame_cnt  out  FW  frames seen since reset.
- dump_en  out  CH  per-channel dump window active.
- dump_start  out  CH  one-cycle pulse when dump_en rises.
- dump_stop  out  CH  one-cycle pulse when dump_en falls.
- busy  out  1  OR of dump_en.

Behaviour:
- Reset: rst_n is asynchronous and active-low. It clears all state: frame_cnt=0, dump_en=0, dump_start=0, dump_stop=0, busy=0, channel FSMs to IDLE, guard counter=0, and vs_l/led_l to 0.
- Edge detect:
  - vs_l and led_l are registered copies of vs and led.
  - vs_fall = vs_l & ~vs; led_fall = led_l & ~led. Both are combinational in the current cycle.
  - Because vs_l resets to 0, no spurious edge occurs after reset.
- Frame counter: at each clk edge with vs_fall, frame_cnt <= frame_cnt+1. It wraps modulo 2^FW with no flag.
- Guard: a counter saturates at GUARD; guard_ok = (counter==GUARD). led_fall while !guard_ok is discarded, not queued.
- Channel FSM, all transitions registered:
  - IDLE: mode!=0 -> ARMED.
  - ARMED:
    - mode==0 -> IDLE.
    - mode==1 -> ACTIVE unconditionally.
    - mode==2 -> ACTIVE when vs_fall && frame_cnt==start_frame. The compare uses the pre-increment frame_cnt value.
    - mode==3 -> ACTIVE when led_fall && guard_ok.
  - ACTIVE:
    - dump_en=1.
    - On entry, remaining <= len.
    - Each vs_fall after entry: if len!=0 and remaining==1 -> DONE, else remaining <= remaining-1. The entry frame's own vs_fall does not count.
    - len==0 stays ACTIVE forever.
    - Mode changes are ignored in ACTIVE.
  - DONE: dump_en=0. rearm[i] -> ARMED. Otherwise stays.
- Latency: dump_en rises on the same clk edge that samples the trigger. Mode 1 therefore gives IDLE at edge 1, ARMED at edge 2, and dump_en=1 after edge 3 following reset release.
- dump_start[i] is high exactly the one cycle after the ARMED->ACTIVE transition edge. dump_stop[i] is high the one cycle after the ACTIVE->DONE edge.
- busy is the registered OR of next-state dump_en.
- Simultaneous events:
  - rearm in any state other than DONE is ignored.
  - A trigger and mode==0 in the same ARMED cycle: mode==0 wins -> IDLE.
  - vs_fall and led_fall in the same cycle are handled independently per channel.
- Widths: start_frame compare is full FW bits. remaining is LENW bits, and the decrement never underflows thanks to the ==1 check.
- Reset mid-window: dump_en drops asynchronously with no dump_stop pulse.

Test Plan:
- Mode 1, ch0, len=0, release reset -> dump_en[0]=1 after the 3rd edge, dump_start[0] one pulse, busy=1, never deasserts over 10 frames.
- Mode 2, ch1, start_frame=5, len=3 -> dump_en[1] rises at the vs_fall where frame_cnt goes 5->6. It falls at the vs_fall taking frame_cnt 8->9, with single dump_start/dump_stop pulses.
- Mode 3, ch2, GUARD=100:
  - led falls at cycle 50 -> ignored.
  - led falls again at cycle 300 -> dump_en[2]=1 at that edge.
  - len=1 -> DONE at the next vs_fall.
- Rearm: ch1 DONE, rearm[1] pulse with start_frame=12 -> window reopens at frame 12. A rearm pulse while ch1 is ACTIVE has no effect.
- Wrap: FW=4, run 20 vs frames -> frame_cnt 15->0->4. Mode 2 with start_frame=2 fires at the first visit to 2 only.
- Async reset asserted mid-window -> all outputs 0 immediately, no dump_stop pulse. After release, mode 2 channels re-arm and frame_cnt restarts at 0.
